// File: rtl/clk_div_seq_pkg.sv
// Shared types and default sizes for the clk_divider step sequencer.
//   INDEX_W     width of a divider index (table entry / o_indexSelectLine)
//   DEF_*       default table depth, pointer width and hold-count width
//   seq_state_e sequencer FSM states
package clk_div_seq_pkg;

    localparam int unsigned INDEX_W    = 8;
    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned DEF_HOLD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/clk_div_seq_if.sv
// Control, table-write and divider-side signals of the sequencer.
//   slave  : the sequencer (takes i_* and drives o_*)
//   master : the controlling side (drives i_* and observes o_*)
//   i_start/i_stop/i_loop/i_holdToggles  sequence control
//   i_wrEn/i_wrAddr/i_wrData             table write port
//   i_divClk                             divider output clock (same domain)
//   o_divEna/o_indexSelectLine           divider controls
//   o_stepIdx/o_busy/o_done              status
interface clk_div_seq_if
    import clk_div_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned HOLD_W = DEF_HOLD_W
) ();

    logic               i_start;
    logic               i_stop;
    logic               i_loop;
    logic [HOLD_W-1:0]  i_holdToggles;
    logic               i_wrEn;
    logic [ADDR_W-1:0]  i_wrAddr;
    logic [INDEX_W-1:0] i_wrData;
    logic               i_divClk;
    logic               o_divEna;
    logic [INDEX_W-1:0] o_indexSelectLine;
    logic [ADDR_W-1:0]  o_stepIdx;
    logic               o_busy;
    logic               o_done;

    modport slave (
        input  i_start, i_stop, i_loop, i_holdToggles,
        input  i_wrEn, i_wrAddr, i_wrData, i_divClk,
        output o_divEna, o_indexSelectLine, o_stepIdx, o_busy, o_done
    );

    modport master (
        output i_start, i_stop, i_loop, i_holdToggles,
        output i_wrEn, i_wrAddr, i_wrData, i_divClk,
        input  o_divEna, o_indexSelectLine, o_stepIdx, o_busy, o_done
    );

endinterface

// File: rtl/div_toggle_detect.sv
// Edge detector for the divider output clock.
//   i_clkPin  system clock
//   i_rstPin  synchronous active-high reset
//   i_divClk  divider output (already registered in this clock domain)
//   o_tog_c   combinational: 1 in the cycle i_divClk differs from last cycle
module div_toggle_detect (
    input  logic i_clkPin,
    input  logic i_rstPin,
    input  logic i_divClk,
    output logic o_tog_c
);

    logic r_divClkQ;

    // One-cycle delayed copy of the divider clock.
    always_ff @(posedge i_clkPin) begin
        if (i_rstPin) begin
            r_divClkQ <= 1'b0;
        end else begin
            r_divClkQ <= i_divClk;
        end
    end

    assign o_tog_c = i_divClk ^ r_divClkQ;

endmodule

// File: rtl/clk_div_sequencer.sv
// Steps clk_divider through a table of divide indices, holding each entry for a
// programmed number of divider output toggles. Index changes and enable drops
// are issued only on the cycle after a divider toggle, when the divider's own
// count is near zero, so a lowered terminal count can never be overrun.
//   i_clkPin  system clock (shared with clk_divider)
//   i_rstPin  synchronous active-high reset
//   bus       clk_div_seq_if slave: control, table write, divider side, status
module clk_div_sequencer
    import clk_div_seq_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned HOLD_W = DEF_HOLD_W
) (
    input  logic          i_clkPin,
    input  logic          i_rstPin,
    clk_div_seq_if.slave  bus
);

    logic               w_tog;
    logic [INDEX_W-1:0] r_table [DEPTH];

    seq_state_e         r_state;
    logic [ADDR_W-1:0]  r_ptr;
    logic [HOLD_W-1:0]  r_holdCnt;
    logic [HOLD_W-1:0]  r_holdTgt;
    logic               r_stopPend;
    logic               r_divEna;
    logic [INDEX_W-1:0] r_index;
    logic               r_busy;
    logic               r_done;

    logic [HOLD_W-1:0]  w_holdEff;
    logic               w_holdHit;
    logic [ADDR_W-1:0]  w_ptrNext;
    logic               w_haveNext;
    logic               w_canWrap;
    logic               w_stopNow;

    div_toggle_detect u_tog (
        .i_clkPin (i_clkPin),
        .i_rstPin (i_rstPin),
        .i_divClk (bus.i_divClk),
        .o_tog_c  (w_tog)
    );

    // Table write port, active in every state.
    always_ff @(posedge i_clkPin) begin
        if (i_rstPin) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_table[i] <= '0;
            end
        end else if (bus.i_wrEn) begin
            r_table[bus.i_wrAddr] <= bus.i_wrData;
        end
    end

    // A hold of zero toggles would never be reached; run it as one.
    assign w_holdEff  = (bus.i_holdToggles == '0) ? HOLD_W'(1) : bus.i_holdToggles;
    assign w_holdHit  = (r_holdCnt + HOLD_W'(1)) == r_holdTgt;
    assign w_ptrNext  = r_ptr + ADDR_W'(1);
    assign w_haveNext = (r_ptr != ADDR_W'(DEPTH - 1)) && (r_table[w_ptrNext] != '0);
    assign w_canWrap  = bus.i_loop && (r_table[0] != '0);
    // A stop seen on the toggle cycle itself is honoured on that toggle.
    assign w_stopNow  = r_stopPend | bus.i_stop;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge i_clkPin) begin
        if (i_rstPin) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_holdCnt  <= '0;
            r_holdTgt  <= '0;
            r_stopPend <= 1'b0;
            r_divEna   <= 1'b0;
            r_index    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_divEna   <= 1'b0;
                    r_stopPend <= 1'b0;
                    if (bus.i_start && !bus.i_stop) begin
                        if (r_table[0] != '0) begin
                            r_state   <= ST_LOAD;
                            r_ptr     <= '0;
                            r_index   <= r_table[0];
                            r_holdTgt <= w_holdEff;
                            r_busy    <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end

                // Index settles for one cycle before the divider is enabled.
                ST_LOAD: begin
                    if (bus.i_stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state   <= ST_RUN;
                        r_divEna  <= 1'b1;
                        r_holdCnt <= '0;
                    end
                end

                ST_RUN: begin
                    if (bus.i_stop) begin
                        r_stopPend <= 1'b1;
                    end
                    if (w_tog) begin
                        if (w_stopNow) begin
                            r_state    <= ST_IDLE;
                            r_divEna   <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_stopPend <= 1'b0;
                        end else if (w_holdHit) begin
                            r_holdCnt <= '0;
                            r_holdTgt <= w_holdEff;
                            if (w_haveNext) begin
                                r_ptr   <= w_ptrNext;
                                r_index <= r_table[w_ptrNext];
                            end else if (w_canWrap) begin
                                r_ptr   <= '0;
                                r_index <= r_table[0];
                            end else begin
                                r_state  <= ST_IDLE;
                                r_divEna <= 1'b0;
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                            end
                        end else begin
                            r_holdCnt <= r_holdCnt + HOLD_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_divEna          = r_divEna;
    assign bus.o_indexSelectLine = r_index;
    assign bus.o_stepIdx         = r_ptr;
    assign bus.o_busy            = r_busy;
    assign bus.o_done            = r_done;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Self-checking bench for clk_div_sequencer: expected index steps are queued as
// each sequence is launched and popped whenever the DUT index changes.
module tb_clk_div_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clk_div_seq_if bus_if ();

    clk_div_sequencer dut (
        .i_clkPin (clk),
        .i_rstPin (rst),
        .bus      (bus_if)
    );

    typedef struct {
        logic [7:0] idx;
        logic [2:0] step;
        int         tog;   // toggles expected in the previous step, -1 = don't care
    } exp_t;

    exp_t       q_exp [$];
    int         n_cmp       = 0;
    int         n_err       = 0;
    int         done_cnt    = 0;
    int         tog_cnt     = 0;
    int         exp_end_tog = -1;
    bit         quiet       = 1'b1;
    bit         seen_act    = 1'b0;
    bit         tog_last    = 1'b0;
    logic       div_p       = 1'b0;
    logic       ena_p       = 1'b0;
    logic       done_p      = 1'b0;
    logic [7:0] idx_p       = '0;

    initial forever #5 clk = ~clk;

    // Divider stand-in: output toggles every 4 system clocks.
    initial begin
        bus_if.i_divClk = 1'b0;
        forever begin
            repeat (4) @(posedge clk);
            #1 bus_if.i_divClk = ~bus_if.i_divClk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: scoreboard pop on index change plus per-cycle invariants.
    always @(negedge clk) begin : mon
        logic cur_tog;
        exp_t e;
        cur_tog = (bus_if.i_divClk != div_p);
        div_p   = bus_if.i_divClk;
        if (quiet) begin
            tog_cnt = 0;
        end else begin
            if (bus_if.o_indexSelectLine != idx_p) begin
                if (bus_if.o_divEna) check_eq("idx_chg_on_tog", 32'(tog_last), 32'd1);
                if (q_exp.size() == 0) begin
                    check_eq("unexpected_idx", 32'(bus_if.o_indexSelectLine), 32'(idx_p));
                end else begin
                    e = q_exp.pop_front();
                    check_eq("step_idx", 32'(bus_if.o_indexSelectLine), 32'(e.idx));
                    check_eq("step_ptr", 32'(bus_if.o_stepIdx), 32'(e.step));
                    if (e.tog >= 0) check_eq("step_tog", 32'(tog_cnt), 32'(e.tog));
                end
                tog_cnt = 0;
            end
            if (ena_p && !bus_if.o_divEna) begin
                check_eq("ena_fall_on_tog", 32'(tog_last), 32'd1);
                if (exp_end_tog >= 0) check_eq("end_tog", 32'(tog_cnt), 32'(exp_end_tog));
                tog_cnt = 0;
            end
            if (bus_if.o_divEna) check_eq("idx0_while_ena", 32'(bus_if.o_indexSelectLine == 8'd0), 32'd0);
            if (bus_if.o_done) begin
                done_cnt++;
                check_eq("done_width", 32'(done_p), 32'd0);
            end
            if (bus_if.o_busy || bus_if.o_divEna) seen_act = 1'b1;
            if (bus_if.o_divEna && cur_tog) tog_cnt++;
        end
        tog_last = cur_tog;
        idx_p    = bus_if.o_indexSelectLine;
        ena_p    = bus_if.o_divEna;
        done_p   = bus_if.o_done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] idx, input logic [2:0] step, input int tog);
        exp_t e;
        e.idx  = idx;
        e.step = step;
        e.tog  = tog;
        q_exp.push_back(e);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        bus_if.i_wrEn   = 1'b1;
        bus_if.i_wrAddr = addr;
        bus_if.i_wrData = data;
        tick(1);
        bus_if.i_wrEn   = 1'b0;
    endtask

    task automatic pulse_start();
        bus_if.i_start = 1'b1;
        tick(1);
        bus_if.i_start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus_if.i_stop = 1'b1;
        tick(1);
        bus_if.i_stop = 1'b0;
    endtask

    task automatic wait_q(input string tag, input int sz, input int budget);
        int n = 0;
        while (q_exp.size() > sz && n < budget) begin
            tick(1);
            n++;
        end
        check_eq(tag, 32'(q_exp.size()), 32'(sz));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus_if.o_busy && n < budget) begin
            tick(1);
            n++;
        end
        check_eq(tag, 32'(bus_if.o_busy), 32'd0);
        tick(2);
    endtask

    initial begin
        int d0;
        int n;
        bus_if.i_start       = 1'b0;
        bus_if.i_stop        = 1'b0;
        bus_if.i_loop        = 1'b0;
        bus_if.i_holdToggles = 16'd2;
        bus_if.i_wrEn        = 1'b0;
        bus_if.i_wrAddr      = 3'd0;
        bus_if.i_wrData      = 8'd0;

        // Reset values
        tick(3);
        check_eq("rst_ena",  32'(bus_if.o_divEna), 32'd0);
        check_eq("rst_idx",  32'(bus_if.o_indexSelectLine), 32'd0);
        check_eq("rst_ptr",  32'(bus_if.o_stepIdx), 32'd0);
        check_eq("rst_busy", 32'(bus_if.o_busy), 32'd0);
        check_eq("rst_done", 32'(bus_if.o_done), 32'd0);
        rst = 1'b0;
        tick(1);
        quiet = 1'b0;

        // 1: single pass 10,20,30 with hold 2
        wr(3'd0, 8'd10); wr(3'd1, 8'd20); wr(3'd2, 8'd30);
        bus_if.i_holdToggles = 16'd2;
        bus_if.i_loop        = 1'b0;
        exp_end_tog = 2;
        d0 = done_cnt;
        push(8'd10, 3'd0, -1); push(8'd20, 3'd1, 2); push(8'd30, 3'd2, 2);
        pulse_start();
        wait_idle("t1_idle", 300);
        check_eq("t1_q",    32'(q_exp.size()), 32'd0);
        check_eq("t1_done", 32'(done_cnt - d0), 32'd1);
        check_eq("t1_ena",  32'(bus_if.o_divEna), 32'd0);
        check_eq("t1_idx",  32'(bus_if.o_indexSelectLine), 32'd30);

        // 2: looping, wrap 30 -> 10, done only on stop
        bus_if.i_loop = 1'b1;
        exp_end_tog = -1;
        d0 = done_cnt;
        push(8'd10, 3'd0, -1); push(8'd20, 3'd1, 2); push(8'd30, 3'd2, 2);
        push(8'd10, 3'd0, 2);  push(8'd20, 3'd1, 2);
        pulse_start();
        wait_q("t2_drain", 0, 300);
        check_eq("t2_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("t2_ptr",     32'(bus_if.o_stepIdx), 32'd1);
        pulse_stop();
        wait_idle("t2_idle", 100);
        check_eq("t2_done", 32'(done_cnt - d0), 32'd1);
        check_eq("t2_ena",  32'(bus_if.o_divEna), 32'd0);

        // 3: stop one toggle before the hold completes; stop wins
        bus_if.i_loop = 1'b0;
        exp_end_tog = 2;
        d0 = done_cnt;
        push(8'd10, 3'd0, -1); push(8'd20, 3'd1, 2);
        pulse_start();
        n = 0;
        while (!(q_exp.size() == 0 && tog_cnt == 1) && n < 300) begin
            tick(1);
            n++;
        end
        check_eq("t3_sync", 32'(tog_cnt), 32'd1);
        pulse_stop();
        wait_idle("t3_idle", 100);
        check_eq("t3_idx",  32'(bus_if.o_indexSelectLine), 32'd20);
        check_eq("t3_done", 32'(done_cnt - d0), 32'd1);
        check_eq("t3_q",    32'(q_exp.size()), 32'd0);

        // 4: empty table -> immediate done; start+stop ignored
        wr(3'd0, 8'd0);
        d0 = done_cnt;
        seen_act = 1'b0;
        pulse_start();
        check_eq("t4_done_pulse", 32'(bus_if.o_done), 32'd1);
        tick(5);
        check_eq("t4_no_act", 32'(seen_act), 32'd0);
        check_eq("t4_done",   32'(done_cnt - d0), 32'd1);
        wr(3'd0, 8'd10);
        d0 = done_cnt;
        bus_if.i_start = 1'b1;
        bus_if.i_stop  = 1'b1;
        tick(1);
        bus_if.i_start = 1'b0;
        bus_if.i_stop  = 1'b0;
        tick(5);
        check_eq("t4_ss_act",  32'(seen_act), 32'd0);
        check_eq("t4_ss_done", 32'(done_cnt - d0), 32'd0);

        // 5: rewrite step 1 while it is active; hold 0 acts as 1
        bus_if.i_holdToggles = 16'd0;
        bus_if.i_loop        = 1'b1;
        exp_end_tog = -1;
        d0 = done_cnt;
        push(8'd10, 3'd0, -1); push(8'd20, 3'd1, 1); push(8'd30, 3'd2, 1);
        push(8'd10, 3'd0, 1);  push(8'd99, 3'd1, 1); push(8'd30, 3'd2, 1);
        pulse_start();
        wait_q("t5_at_step1", 4, 300);
        wr(3'd1, 8'd99);
        wait_q("t5_drain", 0, 300);
        pulse_stop();
        wait_idle("t5_idle", 100);
        check_eq("t5_done", 32'(done_cnt - d0), 32'd1);
        check_eq("t5_idx",  32'(bus_if.o_indexSelectLine), 32'd30);

        // 6: reset in RUN, then restart through LOAD
        wr(3'd1, 8'd20);
        bus_if.i_holdToggles = 16'd2;
        push(8'd10, 3'd0, -1);
        pulse_start();
        n = 0;
        while (!bus_if.o_divEna && n < 50) begin
            tick(1);
            n++;
        end
        check_eq("t6_running", 32'(bus_if.o_divEna), 32'd1);
        quiet = 1'b1;
        rst   = 1'b1;
        tick(1);
        check_eq("t6_rst_ena",  32'(bus_if.o_divEna), 32'd0);
        check_eq("t6_rst_idx",  32'(bus_if.o_indexSelectLine), 32'd0);
        check_eq("t6_rst_ptr",  32'(bus_if.o_stepIdx), 32'd0);
        check_eq("t6_rst_busy", 32'(bus_if.o_busy), 32'd0);
        rst = 1'b0;
        tick(1);
        q_exp.delete();
        quiet = 1'b0;
        pulse_start();
        check_eq("t6_tbl_cleared", 32'(bus_if.o_done), 32'd1);
        check_eq("t6_tbl_busy",    32'(bus_if.o_busy), 32'd0);
        wr(3'd0, 8'd10); wr(3'd1, 8'd20);
        d0 = done_cnt;
        push(8'd10, 3'd0, -1); push(8'd20, 3'd1, 2);
        pulse_start();
        check_eq("t6_load_busy", 32'(bus_if.o_busy), 32'd1);
        check_eq("t6_load_ena",  32'(bus_if.o_divEna), 32'd0);
        tick(1);
        check_eq("t6_run_ena",   32'(bus_if.o_divEna), 32'd1);
        wait_q("t6_drain", 0, 300);
        pulse_stop();
        wait_idle("t6_idle", 100);
        check_eq("t6_done", 32'(done_cnt - d0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
